conv_accum_ctrl: RTL and testbench
==================================

# conv_accum_ctrl

Sequencing controller that time-multiplexes one sign-magnitude adder to accumulate a fixed-length stream of sign-magnitude products (one 3x3 convolution window by default) into a single widened result. Sits between the multiplier array and the activation/pooling stage. Accepts one term per cycle under valid/ready, emits one result per window, and handles the overflow and negative-zero cases that the bare adder does not.

## Interface
- WIDTH, 9: input term width, sign-magnitude (bit WIDTH-1 = sign, low WIDTH-1 bits = magnitude)
- ACC_W, 16: accumulator/result width, sign-magnitude; must be ≥ WIDTH
- N_TERMS, 9: terms per window; ≥ 1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort; discards any partial window
- in_valid  in  1  term present
- in_ready  out  1  controller can accept a term
- in_data  in  WIDTH  sign-magnitude term
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  sign-magnitude window sum
- out_ovf  out  1  magnitude saturated at least once in this window

## Operation
- Term accepted when in_valid & in_ready; result consumed when out_valid & out_ready.
- Extension: ext(x) = {x[WIDTH-1], zero-padded magnitude}; sign is never replicated.
- FSM states IDLE, ACCUM, DONE.
- IDLE: in_ready=1. On accept: acc <= ext(in_data), cnt <= 1, ovf <= 0; go DONE if N_TERMS=1, else ACCUM.
- ACCUM: in_ready=1. On accept: acc <= adder(acc, ext(in_data)), cnt <= cnt+1; go DONE when the accepted term is term N_TERMS. No accept: hold.
- DONE: in_ready=0, out_valid=1, out_data=acc, out_ovf=ovf. On out_ready: go IDLE. Stable while stalled.
- Overflow: equal signs and |acc|+|term| > 2^(ACC_W-1)-1 → acc magnitude <= 2^(ACC_W-1)-1, sign kept, ovf <= 1 (sticky for the window). Later terms continue from the saturated value.
- Negative zero: any result with zero magnitude is stored with sign 0.
- clear: highest priority below reset; next state IDLE, acc/cnt/ovf <= 0, out_valid deasserts next cycle; a term offered in the same cycle is dropped (in_ready still reflects the current state; the term is not counted).
- cnt width: $clog2(N_TERMS+1).

## Timing
- Reset (async assert, sync release): state IDLE, acc=0, cnt=0, ovf=0; out_valid=0, out_data=0, out_ovf=0, in_ready=1 after release.
- All outputs registered or decoded from state only; no combinational in→out paths.
- Latency: out_valid rises the cycle after the N_TERMS-th term is accepted.
- Throughput: one window per N_TERMS+1 cycles with no stalls (DONE does not accept terms).
- Reset mid-window: partial sum discarded, no result emitted.
- out_ready held high outside DONE: ignored.

## Structure
- Shared package: state enum (IDLE, ACCUM, DONE), sign-magnitude helpers (ext, magnitude-max constant, negative-zero normalise).
- One sub-module: adder_unit instantiated with WIDTH=ACC_W as the single shared adder; overflow detection and sign-zero normalisation live in the controller, not the adder.

## Test plan
- Defaults; terms +1..+9, no stalls → out_data=16'h002D, out_ovf=0, out_valid exactly 1 cycle after 9th accept.
- Defaults; terms -5 (9'h105), +5, then seven +0 → out_data=16'h0000 (sign bit 0), out_ovf=0.
- ACC_W=10; nine terms +255 (9'h0FF) → out_data=10'h1FF, out_ovf=1; next window of nine +1 → 10'h009, out_ovf=0.
- Defaults; out_ready=0 for 10 cycles in DONE → out_data/out_ovf stable, in_ready=0, in_valid pulses ignored; release → IDLE next cycle.
- Defaults; 4 terms +7 then clear, then nine +2 → single result 16'h0012.
- Defaults; rst_n low for 1 cycle after 5 terms → all outputs 0 immediately, no result; following nine +1 → 16'h0009.

Source files
------------

// File: rtl/conv_accum_ctrl_pkg.sv
// Shared types and sign-magnitude helpers for the convolution window accumulator.
package conv_accum_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Helpers operate on a 32-bit carrier; callers cast to their own widths.
  localparam int unsigned SM_MAX_W = 32;

  // Largest magnitude representable in a w-bit sign-magnitude word.
  function automatic logic [SM_MAX_W-1:0] sm_mag_max(input int unsigned w);
    return (SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1);
  endfunction

  // Widen w_in -> w_out: sign moves to the new MSB, magnitude is zero-padded.
  function automatic logic [SM_MAX_W-1:0] sm_ext(input logic [SM_MAX_W-1:0] x,
                                                 input int unsigned w_in,
                                                 input int unsigned w_out);
    logic [SM_MAX_W-1:0] mag;
    mag = x & sm_mag_max(w_in);
    return mag | (SM_MAX_W'(x[w_in-1]) << (w_out - 1));
  endfunction

  // Zero magnitude always carries a positive sign.
  function automatic logic [SM_MAX_W-1:0] sm_norm(input logic [SM_MAX_W-1:0] x,
                                                  input int unsigned w);
    return ((x & sm_mag_max(w)) == '0) ? '0 : x;
  endfunction

endpackage

// File: rtl/conv_accum_ctrl_adder_unit.sv
// Bare sign-magnitude adder; reports the magnitude carry but neither saturates nor fixes -0.
module adder_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             mag_carry
);

  localparam int unsigned MW = WIDTH - 1;

  logic          sa, sb;
  logic [MW-1:0] ma, mb;
  logic [MW:0]   mag_sum;

  assign sa = a[WIDTH-1];
  assign sb = b[WIDTH-1];
  assign ma = a[MW-1:0];
  assign mb = b[MW-1:0];

  always_comb begin
    mag_sum   = '0;
    sum       = '0;
    mag_carry = 1'b0;
    if (sa == sb) begin
      mag_sum   = {1'b0, ma} + {1'b0, mb};
      sum       = {sa, mag_sum[MW-1:0]};
      mag_carry = mag_sum[MW];
    end else if (ma >= mb) begin
      sum = {sa, ma - mb};
    end else begin
      sum = {sb, mb - ma};
    end
  end

endmodule

// File: rtl/conv_accum_ctrl.sv
// Sequences one shared sign-magnitude adder over N_TERMS inputs and emits one
// saturating, sign-normalised window sum under valid/ready.
module conv_accum_ctrl
  import conv_accum_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned N_TERMS = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned MAG_W = ACC_W - 1;
  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
  localparam logic [MAG_W-1:0] MAG_MAX = MAG_W'(sm_mag_max(ACC_W));

  state_e             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic [ACC_W-1:0]   term_ext;
  logic [ACC_W-1:0]   term_norm;
  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;
  logic               sat;
  logic               accept;
  logic               last_term;
  logic [ACC_W-1:0]   acc_step;

  assign term_ext  = ACC_W'(sm_ext(SM_MAX_W'(in_data), WIDTH, ACC_W));
  assign term_norm = ACC_W'(sm_norm(SM_MAX_W'(term_ext), ACC_W));

  adder_unit #(.WIDTH(ACC_W)) u_adder (
    .a         (acc),
    .b         (term_ext),
    .sum       (add_sum),
    .mag_carry (add_carry)
  );

  // Saturate on same-sign magnitude carry, otherwise keep the normalised sum.
  assign sat       = (acc[ACC_W-1] == term_ext[ACC_W-1]) && add_carry;
  assign acc_step  = sat ? {acc[ACC_W-1], MAG_MAX}
                         : ACC_W'(sm_norm(SM_MAX_W'(add_sum), ACC_W));
  assign accept    = in_valid && in_ready;
  assign last_term = (cnt == CNT_W'(N_TERMS - 1));

  assign out_data = acc;
  assign out_ovf  = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= term_norm;
            cnt <= CNT_W'(1);
            ovf <= 1'b0;
            if (N_TERMS == 1) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
            if (sat) ovf <= 1'b1;
            if (last_term) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_accum_ctrl.sv
// Directed bench: default-width controller plus an ACC_W=10 copy for saturation.
module tb_conv_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [9:0]  b_out_data;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_accum_ctrl u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid && !sel),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready && !sel),
    .out_data  (a_out_data),
    .out_ovf   (a_out_ovf)
  );

  conv_accum_ctrl #(.WIDTH(9), .ACC_W(10), .N_TERMS(9)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid && sel),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready && sel),
    .out_data  (b_out_data),
    .out_ovf   (b_out_ovf)
  );

  assign in_ready  = sel ? b_in_ready  : a_in_ready;
  assign out_valid = sel ? b_out_valid : a_out_valid;
  assign out_ovf   = sel ? b_out_ovf   : a_out_ovf;
  assign out_data  = sel ? {6'b0, b_out_data} : a_out_data;

  // Offer one term and return just after the edge that accepts it.
  task automatic send(input logic [8:0] d);
    int guard;
    guard = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stuck at %0b, want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int guard;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL result_timeout: out_valid=%0b, want 1", out_valid);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data: got %h want 0000", a_out_data); end
    n_cmp++; if (a_out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf: got %0b want 0", a_out_ovf); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_in_ready: got %0b want 1", b_in_ready); end
  endtask

  task automatic test_sum_ramp();
    for (int i = 1; i <= 8; i++) send(9'(i));
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ramp_early_valid: got %0b want 0", out_valid); end
    send(9'd9);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ramp_latency: got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h002D) begin n_bad++; $display("FAIL ramp_data: got %h want 002d", out_data); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL ramp_ovf: got %0b want 0", out_ovf); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ramp_in_ready_done: got %0b want 0", in_ready); end
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ramp_release: got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ramp_in_ready_idle: got %0b want 1", in_ready); end
  endtask

  task automatic test_neg_zero();
    send(9'h105);
    send(9'h005);
    for (int i = 0; i < 7; i++) send(9'h000);
    wait_result();
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL negzero_data: got %h want 0000", out_data); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL negzero_ovf: got %0b want 0", out_ovf); end
    consume();
  endtask

  task automatic test_saturate();
    sel = 1'b1;
    for (int i = 0; i < 9; i++) send(9'h0FF);
    wait_result();
    n_cmp++; if (out_data !== 16'h01FF) begin n_bad++; $display("FAIL sat_data: got %h want 01ff", out_data); end
    n_cmp++; if (out_ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf: got %0b want 1", out_ovf); end
    consume();
    for (int i = 0; i < 9; i++) send(9'h001);
    wait_result();
    n_cmp++; if (out_data !== 16'h0009) begin n_bad++; $display("FAIL sat_next_data: got %h want 0009", out_data); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL sat_next_ovf: got %0b want 0", out_ovf); end
    consume();
    sel = 1'b0;
  endtask

  task automatic test_stall();
    for (int i = 1; i <= 9; i++) send(9'(i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0];
      in_data  = 9'h003;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %0b want 1", c, out_valid); end
      n_cmp++; if (out_data !== 16'h002D) begin n_bad++; $display("FAIL stall_data[%0d]: got %h want 002d", c, out_data); end
      n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL stall_ovf[%0d]: got %0b want 0", c, out_ovf); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", c, in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release_valid: got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) send(9'h007);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 9'h007;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL clear_acc: got %h want 0000", out_data); end
    for (int i = 0; i < 8; i++) send(9'h002);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_early_valid: got %0b want 0", out_valid); end
    send(9'h002);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clear_result_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h0012) begin n_bad++; $display("FAIL clear_data: got %h want 0012", out_data); end
    consume();
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 5; i++) send(9'h001);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL midrst_data: got %h want 0000", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf: got %0b want 0", out_ovf); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %0b want 1", in_ready); end
    for (int i = 0; i < 9; i++) send(9'h001);
    wait_result();
    n_cmp++; if (out_data !== 16'h0009) begin n_bad++; $display("FAIL midrst_next_data: got %h want 0009", out_data); end
    consume();
  endtask

  initial begin
    test_reset();
    test_sum_ramp();
    test_neg_zero();
    test_saturate();
    test_stall();
    test_clear();
    test_reset_mid_window();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
